// File: rtl/dppm_decoder.sv
// dppm_decoder: receive-side D-PPM decoder.
// Synchronizes the photodetector level and detects LED-on edges. It measures
// the clock gap between successive edges and turns each gap into one bit.
// PACKET_SIZE bits are assembled LSB-first into a packet.
//
// Ports:
//   clock    - system clock, rising edge
//   reset    - asynchronous, active-high reset
//   light_in - raw photodetector level, asynchronous to clock
//   data_out - last completed packet; held until the next valid
//   valid    - one-cycle strobe, data_out updated this cycle
//   error    - one-cycle strobe, reception aborted (glitch or timeout)
//   busy     - high while a packet is being received
module dppm_decoder #(
    parameter int unsigned PACKET_SIZE   = 16,
    parameter int unsigned INTERVAL_LOW  = 4,
    parameter int unsigned INTERVAL_HIGH = 8,
    parameter int unsigned TOLERANCE     = 2,
    parameter int unsigned COUNTER_SIZE  = 8,
    parameter bit          LED_ON_LEVEL  = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   light_in,
    output logic [PACKET_SIZE-1:0] data_out,
    output logic                   valid,
    output logic                   error,
    output logic                   busy
);

    localparam int unsigned IdxW   = (PACKET_SIZE > 1) ? $clog2(PACKET_SIZE) : 1;
    localparam int unsigned Thresh = (INTERVAL_LOW + INTERVAL_HIGH + 2) / 2;
    localparam int unsigned MinGap = INTERVAL_LOW + 1 - TOLERANCE;
    localparam int unsigned MaxGap = INTERVAL_HIGH + 1 + TOLERANCE;
    localparam logic        LedOff = ~LED_ON_LEVEL;

    localparam logic [COUNTER_SIZE-1:0] ThreshC = COUNTER_SIZE'(Thresh);
    localparam logic [COUNTER_SIZE-1:0] MinGapC = COUNTER_SIZE'(MinGap);
    localparam logic [COUNTER_SIZE-1:0] MaxGapC = COUNTER_SIZE'(MaxGap);
    localparam logic [IdxW-1:0]         LastIdx = IdxW'(PACKET_SIZE - 1);

    typedef enum logic [1:0] {StIdle, StReceive, StDone} state_e;

    logic                    sync1_q, sync2_q, prev_q, strobe_q;
    logic [COUNTER_SIZE-1:0] counter_q;
    state_e                  state_q;
    logic [IdxW-1:0]         idx_q;
    logic [PACKET_SIZE-1:0]  shreg_q, shreg_ins;
    logic                    gap_short, gap_long, bit_one;

    // Two-flop synchronizer, edge history and registered edge strobe. All
    // flops reset to LED-off so a level held on across reset yields one edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= LedOff;
            sync2_q  <= LedOff;
            prev_q   <= LedOff;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= light_in;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            strobe_q <= (sync2_q == LED_ON_LEVEL) && (prev_q != LED_ON_LEVEL);
        end
    end

    // Gap counter: restarts at 1 on every edge, saturates at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter_q <= '0;
        end else if (strobe_q) begin
            counter_q <= COUNTER_SIZE'(1);
        end else if (counter_q != '1) begin
            counter_q <= counter_q + COUNTER_SIZE'(1);
        end
    end

    always_comb begin
        gap_short = counter_q < MinGapC;
        // Past MaxGap means timeout, whether or not an edge arrives now.
        gap_long  = counter_q > MaxGapC;
        bit_one   = counter_q > ThreshC;
        shreg_ins = shreg_q;
        shreg_ins[idx_q] = bit_one;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            shreg_q  <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (strobe_q) begin
                        state_q <= StReceive;
                        idx_q   <= '0;
                        shreg_q <= '0;
                        busy    <= 1'b1;
                    end
                end
                StReceive: begin
                    if (gap_long || (strobe_q && gap_short)) begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (strobe_q) begin
                        shreg_q <= shreg_ins;
                        idx_q   <= idx_q + IdxW'(1);
                        if (idx_q == LastIdx) begin
                            data_out <= shreg_ins;
                            valid    <= 1'b1;
                            busy     <= 1'b0;
                            state_q  <= StDone;
                        end
                    end
                end
                StDone: begin
                    // An edge here already starts the next packet.
                    if (strobe_q) begin
                        state_q <= StReceive;
                        idx_q   <= '0;
                        shreg_q <= '0;
                        busy    <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dppm_decoder.sv
// tb_dppm_decoder: directed, table-driven bench for dppm_decoder with
// default parameters (MIN_GAP=3, THRESH=7, MAX_GAP=11).
module tb_dppm_decoder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        light_in = 1'b0;
    logic [15:0] data_out;
    logic        valid, error, busy;

    int tests  = 0;
    int failed = 0;

    dppm_decoder dut (
        .clock    (clock),
        .reset    (reset),
        .light_in (light_in),
        .data_out (data_out),
        .valid    (valid),
        .error    (error),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    // Passive monitor: counts strobes and busy cycles, records each packet.
    int          valid_cnt = 0;
    int          err_cnt   = 0;
    int          busy_cnt  = 0;
    bit          both_seen = 1'b0;
    logic [15:0] valid_data [64];

    always @(negedge clock) begin
        if (!reset) begin
            if (valid && valid_cnt < 64) valid_data[valid_cnt] = data_out;
            if (valid) valid_cnt = valid_cnt + 1;
            if (error) err_cnt = err_cnt + 1;
            if (busy) busy_cnt = busy_cnt + 1;
            if (valid && error) both_seen = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Rising pin edge now, next rising edge g clocks later.
    task automatic pulse_wait(input int g);
        light_in = 1'b1;
        @(negedge clock);
        light_in = 1'b0;
        repeat (g - 1) @(negedge clock);
    endtask

    // Start marker, 16 data gaps, final edge, then `tail` clocks to the next edge.
    task automatic send_packet(input logic [15:0] d, input int lo, input int hi, input int tail);
        for (int i = 0; i < 16; i++) pulse_wait(d[i] ? hi : lo);
        pulse_wait(tail);
    endtask

    typedef struct {
        logic [15:0] data;
        int          lo;
        int          hi;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0, b0, exp_busy;
        logic [15:0] prev;

        vecs[0] = '{data: 16'hAAAA, lo: 5, hi: 9,  exp: 16'hAAAA};
        vecs[1] = '{data: 16'hAAAA, lo: 7, hi: 8,  exp: 16'hAAAA};
        vecs[2] = '{data: 16'h5555, lo: 3, hi: 11, exp: 16'h5555};
        vecs[3] = '{data: 16'h1234, lo: 5, hi: 9,  exp: 16'h1234};
        vecs[4] = '{data: 16'hFFFF, lo: 6, hi: 10, exp: 16'hFFFF};
        vecs[5] = '{data: 16'h0000, lo: 4, hi: 10, exp: 16'h0000};

        #1;
        check("reset_data", 32'(data_out), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_error", 32'(error), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        for (int k = 0; k < 6; k++) begin
            v0 = valid_cnt; e0 = err_cnt; b0 = busy_cnt;
            exp_busy = 0;
            for (int i = 0; i < 16; i++) exp_busy += vecs[k].data[i] ? vecs[k].hi : vecs[k].lo;
            send_packet(vecs[k].data, vecs[k].lo, vecs[k].hi, 10);
            check($sformatf("vec%0d_valid_count", k), 32'(valid_cnt - v0), 32'd1);
            check($sformatf("vec%0d_error_count", k), 32'(err_cnt - e0), 32'd0);
            check($sformatf("vec%0d_data", k), 32'(data_out), 32'(vecs[k].exp));
            check($sformatf("vec%0d_busy_cycles", k), 32'(busy_cnt - b0), 32'(exp_busy));
        end

        // Timeout: last edge, then silence; error exactly when counter hits 12.
        prev = data_out;
        v0 = valid_cnt; e0 = err_cnt;
        repeat (3) pulse_wait(5);
        light_in = 1'b1;
        @(negedge clock);
        light_in = 1'b0;
        repeat (14) @(negedge clock);
        check("timeout_early_error", 32'(error), 32'h0);
        check("timeout_early_busy", 32'(busy), 32'h1);
        @(negedge clock);
        check("timeout_error", 32'(error), 32'h1);
        check("timeout_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clock);
        check("timeout_error_count", 32'(err_cnt - e0), 32'd1);
        check("timeout_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("timeout_data_held", 32'(data_out), 32'(prev));

        // Glitch: gap of 2 mid-packet, then recovery with an all-ones packet.
        v0 = valid_cnt; e0 = err_cnt;
        repeat (3) pulse_wait(5);
        pulse_wait(2);
        pulse_wait(10);
        check("glitch_error_count", 32'(err_cnt - e0), 32'd1);
        check("glitch_busy", 32'(busy), 32'h0);
        check("glitch_data_held", 32'(data_out), 32'(prev));
        send_packet(16'hFFFF, 5, 9, 10);
        check("glitch_recover_valid", 32'(valid_cnt - v0), 32'd1);
        check("glitch_recover_error", 32'(err_cnt - e0), 32'd1);
        check("glitch_recover_data", 32'(data_out), 32'hFFFF);

        // Reset after 8 bits: outputs clear immediately, then a clean packet.
        repeat (9) pulse_wait(5);
        check("midreset_busy_before", 32'(busy), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("midreset_data", 32'(data_out), 32'h0);
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_valid", 32'(valid), 32'h0);
        check("midreset_error", 32'(error), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        v0 = valid_cnt; e0 = err_cnt;
        send_packet(16'h1234, 5, 9, 10);
        check("postreset_valid", 32'(valid_cnt - v0), 32'd1);
        check("postreset_error", 32'(err_cnt - e0), 32'd0);
        check("postreset_data", 32'(data_out), 32'h1234);

        // Back-to-back: next start edge as soon as the edge detector allows.
        v0 = valid_cnt; e0 = err_cnt;
        send_packet(16'hC3A5, 5, 9, 2);
        send_packet(16'h0F0F, 5, 9, 10);
        check("b2b_valid_count", 32'(valid_cnt - v0), 32'd2);
        check("b2b_error_count", 32'(err_cnt - e0), 32'd0);
        check("b2b_first_data", 32'(valid_data[v0]), 32'hC3A5);
        check("b2b_second_data", 32'(valid_data[v0 + 1]), 32'h0F0F);
        check("b2b_data_out", 32'(data_out), 32'h0F0F);

        check("valid_error_exclusive", 32'(both_seen), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
